// File: rtl/mul_iter.sv
// mul_iter: iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Define MUL_EARLY_EXIT_EN to finish once the remaining multiplier bits are all zero.
module mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic sign_neg_q, sign_neg_d;
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [4:0] cnt_q, cnt_d;
  logic sa, sb, finish;
  logic [32:0] sum;
  logic [63:0] shifted, prod_raw, prod;
  always_comb begin
    sa = (^in_op) & in_a[31];
    sb = (in_op == 2'b01) & in_b[31];
    sum = {1'b0, acc_q} + {1'b0, mplier_q[0] ? mcand_q : 32'd0};
    shifted = {sum, mplier_q[31:1]};
`ifdef MUL_EARLY_EXIT_EN
    // Bits above position 31-cnt of mplier already hold product bits, so mask them off.
    finish = (cnt_q == 5'd31) || (((mplier_q >> 1) << ({1'b0, cnt_q} + 6'd1)) == 32'd0);
`else
    finish = cnt_q == 5'd31;
`endif
    state_d = state_q;
    op_d = op_q;
    sign_neg_d = sign_neg_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && in_valid) begin
      op_d = in_op;
      sign_neg_d = sa ^ sb;
      mcand_d = sa ? -in_a : in_a;
      mplier_d = sb ? -in_b : in_b;
      acc_d = 32'd0;
      cnt_d = 5'd0;
`ifdef MUL_EARLY_EXIT_EN
      state_d = (mplier_d == 32'd0) ? DONE : RUN;
`else
      state_d = RUN;
`endif
    end else if (state_q == RUN) begin
      {acc_d, mplier_d} = shifted;
      cnt_d = cnt_q + 5'd1;
      if (finish) begin
        state_d = DONE;
`ifdef MUL_EARLY_EXIT_EN
        {acc_d, mplier_d} = shifted >> (5'd31 - cnt_q);
`endif
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= 2'd0;
      sign_neg_q <= 1'b0;
      mcand_q <= 32'd0;
      mplier_q <= 32'd0;
      acc_q <= 32'd0;
      cnt_q <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sign_neg_q <= sign_neg_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    prod_raw = {acc_q, mplier_q};
    prod = sign_neg_q ? -prod_raw : prod_raw;
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    out_result = !out_valid ? '0 : (op_q == 2'b00) ? prod[31:0] : prod[63:32];
  end
endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: table-driven and scoreboard check of mul_iter, including flush/reset corners.
module tb_mul_iter;
  logic clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] in_op;
  logic [31:0] in_a, in_b, out_result;
  int checks = 0, errors = 0;
  logic [31:0] sq[$];

  typedef struct {
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  mul_iter dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] m;
    int l;
    m = (op == 2'b01 && b[31]) ? -b : b;
    l = 0;
    for (int i = 0; i < 32; i++) if (m[i]) l = i + 1;
    return l;
`else
    return 32;
`endif
  endfunction

  task automatic accept_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 0; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
    int n;
    logic [31:0] e;
    accept_op(op, a, b);
    sq.push_back(exp);
    wait_valid(n);
    chk("latency", 32'(n), 32'(exp_lat(op, b)));
    for (int i = 0; i < hold; i++) begin
      chk("hold_result", out_result, exp);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    out_ready = 1;
    e = sq.pop_front();
    chk("result", out_result, e);
    @(posedge clk); #1;
    out_ready = 0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_result_zero", out_result, 32'd0);
  endtask

  task automatic watch_no_valid(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    vec_t tbl[9];
    int n;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    tbl = '{
      '{2'd0, 32'd7,        32'd6,        32'h0000002A},
      '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000},
      '{2'd0, 32'h80000000, 32'h80000000, 32'h00000000},
      '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
      '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{2'd0, 32'd3,        32'd5,        32'h0000000F},
      '{2'd1, 32'h80000000, 32'd1,        32'hFFFFFFFF},
      '{2'd2, 32'h80000000, 32'h80000000, 32'hC0000000}
    };
    rst = 1; flush = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    @(negedge clk);
    rst = 0;

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 0);
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = (i == 0) ? 32'd0 : (i == 1) ? 32'd3 : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), 0);
    end
    run_op(2'd0, 32'd5, 32'd3, 32'h0000000F, 0);
    run_op(2'd0, 32'd9, 32'd0, 32'h00000000, 0);
    run_op(2'd3, 32'd1, 32'h80000000, 32'h00000000, 0);

    // result must stay put while the consumer stalls
    run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);

    // flush ten cycles into a run
    accept_op(2'd0, 32'd100, 32'hF0000001);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1;
    @(posedge clk); #1; flush = 0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    watch_no_valid("flush_no_valid");
    run_op(2'd0, 32'd3, 32'd5, 32'h0000000F, 0);

    // reset ten cycles into a run
    accept_op(2'd1, 32'h12345678, 32'hF0000001);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_result", out_result, 32'd0);
    watch_no_valid("rst_mid_no_valid");
    run_op(2'd0, 32'd3, 32'd5, 32'h0000000F, 0);

    // flush alongside in_valid in IDLE must not accept
    @(negedge clk); in_valid = 1; flush = 1; in_op = 0; in_a = 1; in_b = 1;
    @(posedge clk); #1; in_valid = 0; flush = 0;
    chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
    chk("flush_idle_out_valid", 32'(out_valid), 32'd0);

    // flush wins over out_ready in DONE
    accept_op(2'd3, 32'hFFFFFFFF, 32'd2);
    wait_valid(n);
    chk("flush_done_reached", 32'(out_valid), 32'd1);
    @(negedge clk); flush = 1; out_ready = 1;
    @(posedge clk); #1; flush = 0; out_ready = 0;
    chk("flush_done_out_valid", 32'(out_valid), 32'd0);
    chk("flush_done_result", out_result, 32'd0);
    chk("flush_done_in_ready", 32'(in_ready), 32'd1);
    run_op(2'd2, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
